// File: rtl/vga_map_pkg.sv
// Shared constants for the tile-map blitter: map geometry, bus regions,
// register offsets, engine opcodes and FSM state codes.
package vga_map_pkg;

    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int AW   = 12;

    localparam logic [3:0] REGION_MAP  = 4'd2;
    localparam logic [3:0] REGION_BLIT = 4'd3;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_ORIGIN = 8'h04;
    localparam logic [7:0] REG_SIZE   = 8'h08;
    localparam logic [7:0] REG_FILL   = 8'h0C;
    localparam logic [7:0] REG_STATUS = 8'h10;

    localparam logic [1:0] OP_FILL       = 2'd0;
    localparam logic [1:0] OP_SHIFT_DOWN = 2'd1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FILL_WR = 3'd1;
    localparam logic [2:0] ST_CP_RD   = 3'd2;
    localparam logic [2:0] ST_CP_CAP  = 3'd3;
    localparam logic [2:0] ST_CP_WR   = 3'd4;
    localparam logic [2:0] ST_TOP_WR  = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    // row*40 as (row<<5)+(row<<3): a constant multiply built from shifts.
    function automatic logic [AW-1:0] row_base(input logic [4:0] row);
        logic [AW-1:0] r;
        r = {{(AW-5){1'b0}}, row};
        return (r << 5) + (r << 3);
    endfunction

endpackage

// File: rtl/vga_map_cursor.sv
// Rectangle walker: column/row counters plus an incrementally stepped map
// address. Ports: load (addr, row count), width, shift_mode, step -> addr,
// last_col, last_row.
module vga_map_cursor
    import vga_map_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [4:0]    load_rows,
    input  logic [5:0]    width,
    input  logic          shift_mode,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last_col,
    output logic          last_row
);

    logic [AW-1:0] addr_q, addr_d;
    logic [5:0]    col_q, col_d;
    logic [4:0]    row_q, row_d;
    logic [4:0]    rows_q, rows_d;
    logic [AW-1:0] w_ext;

    assign w_ext    = {{(AW-6){1'b0}}, width};
    assign addr     = addr_q;
    assign last_col = (col_q == width - 6'd1);
    assign last_row = (row_q == rows_q - 5'd1);

    always_comb begin
        addr_d = addr_q;
        col_d  = col_q;
        row_d  = row_q;
        rows_d = rows_q;
        if (load) begin
            addr_d = load_addr;
            col_d  = '0;
            row_d  = '0;
            rows_d = load_rows;
        end else if (step) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + 5'd1;
                // Shift walks rows bottom-up, fill walks top-down.
                if (shift_mode)
                    addr_d = addr_q - (AW'(COLS - 1) + w_ext);
                else
                    addr_d = addr_q + AW'(COLS + 1) - w_ext;
            end else begin
                col_d  = col_q + 6'd1;
                addr_d = addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            rows_q <= '0;
        end else begin
            addr_q <= addr_d;
            col_q  <= col_d;
            row_q  <= row_d;
            rows_q <= rows_d;
        end
    end

endmodule

// File: rtl/vga_map_blitter.sv
// Tile-map blitter: CPU cell writes plus a FILL / SHIFT_DOWN engine sharing
// the map RAM write port. Ports: iomem bus slave, map write port, map
// engine read port, busy/done status.
module vga_map_blitter
    import vga_map_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          iomem_valid,
    input  logic          iomem_ready,
    input  logic [3:0]    iomem_wstrb,
    input  logic [31:0]   iomem_addr,
    input  logic [31:0]   iomem_wdata,
    output logic          blit_iomem_ready,
    output logic [31:0]   blit_iomem_rdata,
    output logic          map_wen,
    output logic [AW-1:0] map_waddr,
    output logic [3:0]    map_wdata,
    output logic          map_ren,
    output logic [AW-1:0] map_raddr,
    input  logic [3:0]    map_rdata,
    output logic          busy,
    output logic          done
);

    logic [2:0]  state_q, state_d;
    logic [5:0]  x0_q, x0_d;
    logic [4:0]  y0_q, y0_d;
    logic [5:0]  w_q, w_d;
    logic [4:0]  h_q, h_d;
    logic [3:0]  tile_q, tile_d;
    logic        err_q, err_d;
    logic        shift_q, shift_d;
    logic [3:0]  hold_q, hold_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic          cpu_hold;
    logic [3:0]    region;
    logic [7:0]    offset;
    logic          accept;
    logic          cpu_wr;
    logic          reg_wr;
    logic          reg_rd;
    logic          idle;
    logic [1:0]    op;
    logic          start;
    logic          start_bad;
    logic          wr_state;
    logic          eng_wr;
    logic          cur_load;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] fill_base;
    logic [AW-1:0] shift_base;
    logic [AW-1:0] load_addr;
    logic [4:0]    load_rows;
    logic          last_col;
    logic          last_row;
    logic          unused_bits;

    // Reserved stall input; the CPU path never waits today.
    assign cpu_hold = 1'b0;

    assign region = iomem_addr[23:20];
    assign offset = iomem_addr[7:0];
    assign accept = iomem_valid && !iomem_ready && !cpu_hold && !reset
                 && (region == REGION_MAP || region == REGION_BLIT);
    assign cpu_wr = accept && region == REGION_MAP && iomem_wstrb[0];
    assign reg_wr = accept && region == REGION_BLIT && iomem_wstrb[0];
    assign reg_rd = accept && region == REGION_BLIT && !iomem_wstrb[0];

    assign idle  = (state_q == ST_IDLE);
    assign busy  = !idle;
    assign done  = (state_q == ST_DONE);
    assign op    = iomem_wdata[2:1];
    assign start = reg_wr && offset == REG_CTRL && iomem_wdata[0] && idle;

    assign start_bad = (op != OP_FILL && op != OP_SHIFT_DOWN)
                    || w_q == '0 || h_q == '0
                    || ({1'b0, x0_q} + {1'b0, w_q} > 7'(COLS))
                    || ({1'b0, y0_q} + {1'b0, h_q} > 6'(ROWS));

    // CPU owns the write port whenever it writes; the engine just waits.
    assign wr_state = state_q == ST_FILL_WR || state_q == ST_CP_WR
                   || state_q == ST_TOP_WR;
    assign eng_wr   = wr_state && !cpu_wr && !reset;

    assign fill_base  = row_base(y0_q) + {{(AW-6){1'b0}}, x0_q};
    assign shift_base = row_base(y0_q + h_q - 5'd1)
                      + {{(AW-6){1'b0}}, x0_q};
    assign load_addr  = (op == OP_SHIFT_DOWN && h_q != 5'd1)
                      ? shift_base : fill_base;
    assign load_rows  = (op == OP_SHIFT_DOWN) ? h_q - 5'd1 : h_q;

    vga_map_cursor u_cursor (
        .clk        (clk),
        .reset      (reset),
        .load       (cur_load),
        .load_addr  (load_addr),
        .load_rows  (load_rows),
        .width      (w_q),
        .shift_mode (shift_q),
        .step       (eng_wr),
        .addr       (cur_addr),
        .last_col   (last_col),
        .last_row   (last_row)
    );

    assign map_wen   = cpu_wr || eng_wr;
    assign map_waddr = cpu_wr ? iomem_addr[AW+1:2]
                     : (eng_wr ? cur_addr : '0);
    assign map_wdata = cpu_wr ? iomem_wdata[3:0]
                     : (!eng_wr ? 4'd0
                     : (state_q == ST_CP_WR ? hold_q : tile_q));
    assign map_ren   = (state_q == ST_CP_RD) && !reset;
    assign map_raddr = map_ren ? cur_addr - AW'(COLS) : '0;

    assign blit_iomem_ready = ready_q;
    assign blit_iomem_rdata = rdata_q;

    assign unused_bits = ^{iomem_addr[31:24], iomem_addr[19:14],
                           iomem_wdata[31:13], iomem_wdata[7:6],
                           iomem_wstrb[3:1]};

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        tile_d   = tile_q;
        err_d    = err_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        ready_d  = accept;
        rdata_d  = '0;
        cur_load = 1'b0;

        if (reg_wr && idle) begin
            case (offset)
                REG_ORIGIN: begin
                    x0_d = iomem_wdata[5:0];
                    y0_d = iomem_wdata[12:8];
                end
                REG_SIZE: begin
                    w_d = iomem_wdata[5:0];
                    h_d = iomem_wdata[12:8];
                end
                REG_FILL: tile_d = iomem_wdata[3:0];
                default: ;
            endcase
        end

        if (reg_rd) begin
            case (offset)
                REG_ORIGIN: rdata_d = {19'd0, y0_q, 2'd0, x0_q};
                REG_SIZE:   rdata_d = {19'd0, h_q, 2'd0, w_q};
                REG_FILL:   rdata_d = {28'd0, tile_q};
                REG_STATUS: rdata_d = {30'd0, err_q, busy};
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = start_bad;
                    if (!start_bad) begin
                        cur_load = 1'b1;
                        shift_d  = (op == OP_SHIFT_DOWN);
                        if (op == OP_FILL)
                            state_d = ST_FILL_WR;
                        else if (h_q == 5'd1)
                            state_d = ST_TOP_WR;
                        else
                            state_d = ST_CP_RD;
                    end
                end
            end
            ST_FILL_WR: begin
                if (eng_wr && last_col && last_row)
                    state_d = ST_DONE;
            end
            ST_CP_RD:  state_d = ST_CP_CAP;
            ST_CP_CAP: begin
                hold_d  = map_rdata;
                state_d = ST_CP_WR;
            end
            ST_CP_WR: begin
                // Last copy step leaves the cursor at the top row start.
                if (eng_wr)
                    state_d = (last_col && last_row) ? ST_TOP_WR : ST_CP_RD;
            end
            ST_TOP_WR: begin
                if (eng_wr && last_col)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            tile_q  <= '0;
            err_q   <= 1'b0;
            shift_q <= 1'b0;
            hold_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            tile_q  <= tile_d;
            err_q   <= err_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_vga_map_blitter.sv
// Directed bench for vga_map_blitter: map RAM model, write monitor, and
// scoreboard queues for bus read data and expected map writes.
module tb_vga_map_blitter;
    import vga_map_pkg::*;

    logic          clk;
    logic          reset;
    logic          iomem_valid;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb;
    logic [31:0]   iomem_addr;
    logic [31:0]   iomem_wdata;
    logic          blit_iomem_ready;
    logic [31:0]   blit_iomem_rdata;
    logic          map_wen;
    logic [AW-1:0] map_waddr;
    logic [3:0]    map_wdata;
    logic          map_ren;
    logic [AW-1:0] map_raddr;
    logic [3:0]    map_rdata;
    logic          busy;
    logic          done;

    vga_map_blitter dut (
        .clk              (clk),
        .reset            (reset),
        .iomem_valid      (iomem_valid),
        .iomem_ready      (iomem_ready),
        .iomem_wstrb      (iomem_wstrb),
        .iomem_addr       (iomem_addr),
        .iomem_wdata      (iomem_wdata),
        .blit_iomem_ready (blit_iomem_ready),
        .blit_iomem_rdata (blit_iomem_rdata),
        .map_wen          (map_wen),
        .map_waddr        (map_waddr),
        .map_wdata        (map_wdata),
        .map_ren          (map_ren),
        .map_raddr        (map_raddr),
        .map_rdata        (map_rdata),
        .busy             (busy),
        .done             (done)
    );

    typedef struct packed {
        int        cyc;
        logic [11:0] a;
        logic [3:0]  d;
    } wr_t;

    localparam logic [31:0] MAPB = 32'h0020_0000;
    localparam logic [31:0] REGB = 32'h0030_0000;

    logic [3:0]  ram [0:4095];
    logic [3:0]  exp_map [0:1199];
    wr_t         wr_log [$];
    wr_t         exp_wr [$];
    logic [31:0] rd_q [$];
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (map_wen) ram[map_waddr] <= map_wdata;
        if (map_ren) map_rdata <= ram[map_raddr];
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        wr_t e;
        if (map_wen) begin
            e.cyc = cyc;
            e.a   = map_waddr;
            e.d   = map_wdata;
            wr_log.push_back(e);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic wr,
                       input logic [31:0] d, input logic [31:0] exp,
                       input string tag);
        int k = 0;
        rd_q.push_back(exp);
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = wr ? 4'hF : 4'h0;
        iomem_valid = 1'b1;
        tick();
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        while (!blit_iomem_ready && k < 3) begin
            tick();
            k++;
        end
        check({tag, "_ack"}, {31'd0, blit_iomem_ready}, 32'd1);
        check({tag, "_rdata"}, blit_iomem_rdata, rd_q.pop_front());
    endtask

    task automatic reg_write(input logic [7:0] off, input logic [31:0] d,
                             input string tag);
        bus(REGB | {24'd0, off}, 1'b1, d, 32'd0, tag);
    endtask

    task automatic reg_read(input logic [7:0] off, input logic [31:0] exp,
                            input string tag);
        bus(REGB | {24'd0, off}, 1'b0, 32'd0, exp, tag);
    endtask

    task automatic wait_done(input int bound, input string tag);
        int c0 = done_cnt;
        int k = 0;
        while (done_cnt == c0 && k < bound) begin
            tick();
            k++;
        end
        check({tag, "_done"}, done_cnt - c0, 32'd1);
    endtask

    task automatic push_exp(input int a, input logic [3:0] d);
        wr_t e;
        e.cyc = 0;
        e.a   = a[11:0];
        e.d   = d;
        exp_wr.push_back(e);
        exp_map[a] = d;
    endtask

    task automatic compare_writes(input string tag);
        int bad = 0;
        int n = exp_wr.size();
        check({tag, "_nwr"}, wr_log.size(), n);
        for (int i = 0; i < n && i < wr_log.size(); i++)
            if (wr_log[i].a !== exp_wr[i].a || wr_log[i].d !== exp_wr[i].d)
                bad++;
        check({tag, "_seq"}, bad, 32'd0);
    endtask

    task automatic map_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 1200; i++)
            if (ram[i] !== exp_map[i]) bad++;
        check({tag, "_map"}, bad, 32'd0);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        exp_wr.delete();
    endtask

    initial begin
        int st;
        int c0;
        int span;

        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_ready = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        repeat (3) tick();
        check("rst_wen", {31'd0, map_wen}, 32'd0);
        check("rst_ren", {31'd0, map_ren}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, blit_iomem_ready}, 32'd0);
        check("rst_rdata", blit_iomem_rdata, 32'd0);
        reset = 1'b0;
        tick();
        reg_read(REG_STATUS, 32'd0, "rst_status");

        // Preload row r with r&15 through back-to-back CPU cell writes.
        clear_logs();
        iomem_valid = 1'b1;
        iomem_wstrb = 4'hF;
        for (int i = 0; i < 1200; i++) begin
            iomem_addr  = MAPB | (i << 2);
            iomem_wdata = (i / 40) & 15;
            exp_map[i]  = 4'((i / 40) & 15);
            tick();
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        tick();
        check("preload_nwr", wr_log.size(), 32'd1200);
        map_check("preload");

        // FILL x0=2 y0=3 w=4 h=2 tile=5
        reg_write(REG_ORIGIN, 32'h0000_0302, "f_org");
        reg_write(REG_SIZE, 32'h0000_0204, "f_size");
        reg_write(REG_FILL, 32'd5, "f_fill");
        clear_logs();
        for (int r = 3; r <= 4; r++)
            for (int c = 2; c <= 5; c++)
                push_exp(r * 40 + c, 4'd5);
        c0 = done_cnt;
        reg_write(REG_CTRL, 32'd1, "f_ctrl");
        st = cyc;
        check("f_busy", {31'd0, busy}, 32'd1);
        wait_done(50, "f");
        check("f_latency", done_cyc - st, 32'd8);
        span = (wr_log.size() >= 8) ? wr_log[7].cyc - wr_log[0].cyc : -1;
        check("f_span", span, 32'd7);
        compare_writes("f");
        repeat (3) tick();
        check("f_one_done", done_cnt - c0, 32'd1);
        check("f_n121", {28'd0, ram[121]}, 32'd3);
        check("f_n126", {28'd0, ram[126]}, 32'd3);
        map_check("f");

        // SHIFT_DOWN x0=0 y0=0 w=10 h=20 tile=0
        reg_write(REG_ORIGIN, 32'd0, "s_org");
        reg_write(REG_SIZE, 32'h0000_140A, "s_size");
        reg_write(REG_FILL, 32'd0, "s_fill");
        clear_logs();
        for (int r = 19; r >= 1; r--)
            for (int c = 0; c < 10; c++)
                push_exp(r * 40 + c, exp_map[(r - 1) * 40 + c]);
        for (int c = 0; c < 10; c++)
            push_exp(c, 4'd0);
        reg_write(REG_CTRL, 32'd3, "s_ctrl");
        st = cyc;
        wait_done(800, "s");
        check("s_latency", done_cyc - st, 32'd580);
        compare_writes("s");
        check("s_row19", {28'd0, ram[19 * 40 + 7]}, 32'd2);
        check("s_row1", {28'd0, ram[40 + 3]}, 32'd0);
        check("s_row0", {28'd0, ram[9]}, 32'd0);
        map_check("s");

        // FILL with 5 CPU writes to cell 400 contending from the first cycle
        reg_write(REG_ORIGIN, 32'h0000_0302, "c_org");
        reg_write(REG_SIZE, 32'h0000_0204, "c_size");
        reg_write(REG_FILL, 32'd7, "c_fill");
        clear_logs();
        for (int k = 0; k < 5; k++)
            push_exp(400, 4'hA);
        for (int r = 3; r <= 4; r++)
            for (int c = 2; c <= 5; c++)
                push_exp(r * 40 + c, 4'd7);
        reg_write(REG_CTRL, 32'd1, "c_ctrl");
        st = cyc;
        iomem_addr  = MAPB | (400 << 2);
        iomem_wdata = 32'hA;
        iomem_wstrb = 4'hF;
        iomem_valid = 1'b1;
        repeat (5) tick();
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        wait_done(50, "c");
        check("c_latency", done_cyc - st, 32'd13);
        compare_writes("c");
        map_check("c");

        // Invalid geometry, invalid op, then a valid start
        reg_write(REG_ORIGIN, 32'd38, "i_org");
        reg_write(REG_SIZE, 32'h0000_0104, "i_size");
        reg_write(REG_FILL, 32'd1, "i_fill");
        clear_logs();
        c0 = done_cnt;
        reg_write(REG_CTRL, 32'd1, "i_ctrl");
        repeat (5) tick();
        check("i_busy", {31'd0, busy}, 32'd0);
        reg_read(REG_STATUS, 32'd2, "i_status");
        reg_write(REG_ORIGIN, 32'd36, "i_org2");
        reg_write(REG_CTRL, 32'd5, "i_badop");
        repeat (3) tick();
        reg_read(REG_STATUS, 32'd2, "i_status_op");
        check("i_nwr", wr_log.size(), 32'd0);
        check("i_nodone", done_cnt - c0, 32'd0);
        for (int c = 36; c < 40; c++)
            push_exp(c, 4'd1);
        reg_write(REG_CTRL, 32'd1, "i_ctrl_ok");
        wait_done(50, "i");
        reg_read(REG_STATUS, 32'd0, "i_status_clr");
        compare_writes("i");

        // Start and SIZE write while busy are acked and ignored
        reg_write(REG_ORIGIN, 32'h0000_0500, "b_org");
        reg_write(REG_SIZE, 32'h0000_0308, "b_size");
        reg_write(REG_FILL, 32'd9, "b_fill");
        clear_logs();
        for (int r = 5; r <= 7; r++)
            for (int c = 0; c < 8; c++)
                push_exp(r * 40 + c, 4'd9);
        c0 = done_cnt;
        reg_write(REG_CTRL, 32'd1, "b_ctrl");
        st = cyc;
        reg_read(REG_STATUS, 32'd1, "b_status_busy");
        reg_write(REG_SIZE, 32'h0000_0101, "b_size_busy");
        reg_write(REG_CTRL, 32'd3, "b_ctrl_busy");
        wait_done(60, "b");
        check("b_latency", done_cyc - st, 32'd24);
        repeat (30) tick();
        check("b_one_done", done_cnt - c0, 32'd1);
        compare_writes("b");
        reg_read(REG_SIZE, 32'h0000_0308, "b_size_kept");
        map_check("b");

        // Reset in the middle of a SHIFT_DOWN
        reg_write(REG_ORIGIN, 32'd0, "r_org");
        reg_write(REG_SIZE, 32'h0000_140A, "r_size");
        reg_write(REG_FILL, 32'd0, "r_fill");
        reg_write(REG_CTRL, 32'd3, "r_ctrl");
        repeat (100) tick();
        check("r_busy_mid", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        wr_log.delete();
        check("r_wen", {31'd0, map_wen}, 32'd0);
        check("r_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("r_nwr", wr_log.size(), 32'd0);
        reg_read(REG_STATUS, 32'd0, "r_status");
        reg_read(REG_SIZE, 32'd0, "r_size_clr");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
